// File: rtl/counter6bit_ctrl_cgrundey.sv
// ---------------------------------------------------------------------------
// counter6bit_ctrl_cgrundey
//
// Run controller for an external 6-bit counter (sync clear, increments while
// enabled). A run clears the counter for CLR_CYCLES cycles, then enables it
// until it reaches the latched target. Pause holds the counter. Abort cancels
// the run. DONE is reported until it is acknowledged or a new run starts.
//
// Parameters:
//   CLR_CYCLES  cycles ctr_clr is held at each run start (1..4)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   clr         synchronous active-high reset
//   start       begin a run (accepted in IDLE and DONE)
//   target[5:0] terminal count, latched when start is accepted
//   pause       holds the counter while high during a run
//   abort       cancels any run, forcing IDLE
//   ack         releases DONE
//   count[5:0]  current value of the controlled counter
//   ctr_enable  counter increment enable (RUN)
//   ctr_clr     counter clear (CLEAR)
//   busy        high in CLEAR, RUN and HOLD
//   done        completion flag (DONE)
//   done_cnt    completed runs, saturating at 255
//
// Configuration macro:
//   COUNTER6BIT_CTRL_AUTORELOAD_EN  when defined, DONE lasts one cycle and
//   the same target is re-run automatically (ack is ignored).
// ---------------------------------------------------------------------------
module counter6bit_ctrl_cgrundey #(
    parameter int CLR_CYCLES = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [5:0] target,
    input  logic       pause,
    input  logic       abort,
    input  logic       ack,
    input  logic [5:0] count,
    output logic       ctr_enable,
    output logic       ctr_clr,
    output logic       busy,
    output logic       done,
    output logic [7:0] done_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CLR_LAST = 2'(CLR_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [5:0] tgt_r;
    logic [5:0] tgt_s;
    logic [1:0] clr_cnt_r;
    logic [1:0] clr_cnt_s;
    logic       done_inc_s;
    logic [5:0] tgt_m1_s;

    // Completion compare value; tgt_r is never 0 while in RUN, so no wrap.
    always_comb begin
        tgt_m1_s = tgt_r - 6'd1;
    end

    // Next-state, target latch, clear-cycle counter and DONE-entry strobe.
    always_comb begin
        state_s    = state_r;
        tgt_s      = tgt_r;
        clr_cnt_s  = clr_cnt_r;
        done_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    tgt_s     = target;
                    clr_cnt_s = 2'd0;
                    if (target == 6'd0) begin
                        state_s    = ST_DONE;
                        done_inc_s = 1'b1;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (clr_cnt_r == CLR_LAST) begin
                    state_s   = ST_RUN;
                    clr_cnt_s = 2'd0;
                end else begin
                    clr_cnt_s = clr_cnt_r + 2'd1;
                end
            end
            ST_RUN: begin
                // Completion is checked before pause so it wins in the same cycle.
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (count == tgt_m1_s) begin
                    state_s    = ST_DONE;
                    done_inc_s = 1'b1;
                end else if (pause) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (!pause) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
`ifdef COUNTER6BIT_CTRL_AUTORELOAD_EN
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (tgt_r == 6'd0) begin
                    state_s    = ST_DONE;
                    done_inc_s = 1'b1;
                end else begin
                    state_s   = ST_CLEAR;
                    clr_cnt_s = 2'd0;
                end
`else
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    tgt_s     = target;
                    clr_cnt_s = 2'd0;
                    if (target == 6'd0) begin
                        state_s    = ST_DONE;
                        done_inc_s = 1'b1;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end else if (ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers; outputs are registered decodes of the next state so
    // they always match the current state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r    <= ST_IDLE;
            tgt_r      <= 6'd0;
            clr_cnt_r  <= 2'd0;
            done_cnt   <= 8'd0;
            ctr_enable <= 1'b0;
            ctr_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            tgt_r      <= tgt_s;
            clr_cnt_r  <= clr_cnt_s;
            ctr_enable <= (state_s == ST_RUN);
            ctr_clr    <= (state_s == ST_CLEAR);
            busy       <= (state_s == ST_CLEAR) || (state_s == ST_RUN) || (state_s == ST_HOLD);
            done       <= (state_s == ST_DONE);
            if (done_inc_s && (done_cnt != 8'hFF)) begin
                done_cnt <= done_cnt + 8'd1;
            end else begin
                done_cnt <= done_cnt;
            end
        end
    end

endmodule

// File: doc/counter6bit_ctrl_cgrundey.md
COUNTER6BIT_CTRL_CGRUNDEY -- requirements
Module: counter6bit_ctrl_cgrundey

Interface
REQ-001 Parameter CLR_CYCLES, default 1, number of consecutive cycles ctr_clr SHALL be held per run start (legal 1..4).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a run to target.
REQ-005 target  input  6  terminal count, sampled only when start is accepted.
REQ-006 pause  input  1  level; holds the counter while high during a run.
REQ-007 abort  input  1  terminates any run; highest priority after clr.
REQ-008 ack  input  1  acknowledges completion, releasing DONE.
REQ-009 count  input  6  current value from the controlled 6-bit counter (sync clear, increments when enabled).
REQ-010 ctr_enable  output  1  enable to the counter.
REQ-011 ctr_clr  output  1  clear to the counter.
REQ-012 busy  output  1  high in CLEAR, RUN and HOLD.
REQ-013 done  output  1  completion flag.
REQ-014 done_cnt  output  8  number of completed runs, saturating at 255.

Function
REQ-015 The block SHALL implement states IDLE, CLEAR, RUN, HOLD, DONE; ctr_enable, ctr_clr, busy, done SHALL be Moore decodes of state only.
REQ-016 Decodes SHALL be: CLEAR -> ctr_clr=1; RUN -> ctr_enable=1; HOLD -> both 0; DONE -> done=1; IDLE -> all 0.
REQ-017 IDLE or DONE with start=1 SHALL latch target into tgt_q and go to CLEAR; if target=0, go directly to DONE instead, with no clear or counting.
REQ-018 CLEAR SHALL last exactly CLR_CYCLES cycles, then go to RUN; count is 0 in the first RUN cycle.
REQ-019 In RUN, if count == tgt_q-1, next state SHALL be DONE, so count equals tgt_q on entry to DONE and no increment beyond tgt_q occurs.
REQ-020 In RUN with pause=1 and count != tgt_q-1, next state SHALL be HOLD; completion wins over pause in the same cycle.
REQ-021 HOLD SHALL return to RUN on the first cycle pause=0; count SHALL not change in HOLD.
REQ-022 abort=1 in CLEAR, RUN, HOLD or DONE SHALL force IDLE next cycle; abort overrides start, pause, ack and completion; done_cnt is not incremented by an aborted run.
REQ-023 DONE SHALL persist until ack=1 (-> IDLE) or start=1 (-> new run per REQ-017); start wins over ack.
REQ-024 start is ignored in CLEAR, RUN, HOLD; ack is ignored outside DONE.
REQ-025 done_cnt SHALL increment by 1 on each entry to DONE (including target=0 runs) and hold at 255.
REQ-026 tgt_q-1 SHALL be computed in 6 bits; tgt_q=0 never reaches RUN, so no wrap occurs; tgt_q=63 ends with count=63.

Reset
REQ-027 On a clock edge with clr=1: state=IDLE, tgt_q=0, CLEAR-cycle counter=0, done_cnt=0; hence ctr_enable=0, ctr_clr=0, busy=0, done=0 on the following cycle.
REQ-028 clr SHALL override every input in any state, including mid-run; the controlled counter is not cleared by clr via this block.

Configuration
REQ-029 Macro COUNTER6BIT_CTRL_AUTORELOAD_EN: when defined, DONE SHALL last exactly one cycle and then go to CLEAR with the same tgt_q (periodic mode, done is a one-cycle pulse, ack ignored); abort still forces IDLE.
REQ-030 When the macro is undefined, DONE SHALL be sticky per REQ-023.

Verification
REQ-031 clr 1 cycle, then start with target=5, CLR_CYCLES=1 -> ctr_clr 1 cycle, ctr_enable exactly 5 cycles, done=1 with count=5, done_cnt=1.
REQ-032 target=5, pause=1 for 3 cycles when count=2 -> ctr_enable low 3 cycles, done with count=5 after 8 total enable+hold cycles.
REQ-033 target=3, pause and count=2 in the same cycle -> DONE next cycle, no HOLD, count=3.
REQ-034 start with target=0 -> DONE next cycle, ctr_clr and ctr_enable never asserted, done_cnt=1.
REQ-035 abort in RUN at count=4, target=10 -> IDLE next cycle, count stays 5, done_cnt unchanged; clr asserted mid-run -> all outputs 0.
REQ-036 With COUNTER6BIT_CTRL_AUTORELOAD_EN, target=2, CLR_CYCLES=2 -> repeating 5-cycle pattern (clr,clr,en,en,done), done_cnt increments every 5 cycles.
